pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Program-counter generator for the MIPS core: owns the PC register and selects the next PC.
//  Sources: sequential, branch, jump, jr, exception vector and eret return.
//  Adds what the combinational next-PC mux lacked: stall hold, a pending-redirect latch,
//  an EPC/EXL exception context, and trapping of misaligned jr targets. Feeds IF; driven by ID/EX.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value loaded on reset
//  EXC_VEC   32'h0000_4180  exception handler entry address
//  PC_INC    4              sequential increment in bytes
// PORTS
//  clk        in   1   core clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  stall      in   1   hold PC (pipeline freeze)
//  npc_op     in   3   000 seq, 001 branch, 010 j, 011 jr, 100 exception, 101 eret, 11x = seq
//  d_ins26    in   26  jump index field
//  d_btypc    in   32  branch target
//  d_rfrs32   in   32  jr target (rs value)
//  exc_pc     in   32  PC of faulting instruction, sampled when npc_op=100
//  pc         out  32  current PC (registered)
//  npc        out  32  next PC (combinational)
//  epc        out  32  saved exception PC (registered)
//  exl        out  1   exception level flag (registered)
//  pend       out  1   redirect pending flag (registered)
//  addr_err   out  1   one-cycle pulse: misaligned jr trapped
// BEHAVIOUR
//  Reset, async on rst_n low: pc=RESET_PC, epc=0, exl=0, pend=0, pend_tgt=0, addr_err=0.
//  Target calc: seq=pc+PC_INC; j={pc[31:28],d_ins26,2'b00}; branch=d_btypc; jr=d_rfrs32;
//    exc=EXC_VEC; eret=epc. All arithmetic is mod 2^32, so pc wraps 32'hFFFF_FFFC -> 0.
//  jr with d_rfrs32[1:0]!=0 is treated as an exception: target=EXC_VEC, epc<=pc (when exl=0),
//    exl<=1, addr_err=1 for that edge only.
//  Priority at each edge, high to low:
//    1. exception/misaligned jr: taken even when stall=1. pend is cleared.
//       epc<=exc_pc (pc for misaligned jr), but only when exl=0; exl<=1.
//    2. stall=1 with npc_op in {branch, j, jr, eret}: pc holds.
//       pend<=1; pend_tgt<=computed target. A later redirect during the same stall overwrites it.
//    3. stall=1 otherwise: pc, pend and pend_tgt hold.
//    4. stall=0, pend=1: pc<=pend_tgt; pend<=0. npc_op is ignored that cycle unless it is priority 1.
//    5. stall=0: pc<=target(npc_op). eret additionally clears exl.
//  eret while stalled: exl clears when the pending target is applied, not at the latch.
//  eret with exl=0: still returns to epc; exl stays 0.
//  npc always reflects the value pc will load at the next edge, given current inputs.
//  Latency: 1 cycle from npc_op to pc, or first unstalled edge if the redirect was stalled.
// TESTING
//  Reset release, npc_op=000, no stall, 3 edges -> pc 3000,3004,3008,300C.
//  pc=3010, op=010, d_ins26=26'h0000C40 -> pc=00003100; op=001, d_btypc=3200 -> pc=3200.
//  stall=1 2 cycles with op=001, d_btypc=3400 in first -> pc holds, pend=1; stall=0, op=000 -> pc=3400, pend=0.
//  op=100, exc_pc=3050, stall=1 -> pc=4180, epc=3050, exl=1. 2nd op=100, exc_pc=3060 -> epc stays 3050.
//    op=101 -> pc=3050, exl=0.
//  pc=3020, op=011, d_rfrs32=3102 -> addr_err pulse, pc=4180, epc=3020, exl=1.
//  rst_n low mid-stall with pend=1 -> pc=3000, pend=0, exl=0 immediately, without a clock edge.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: owns the PC, picks the next PC, latches redirects
// that arrive during a stall, and keeps the EPC/EXL exception context.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter int          PC_INC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [2:0]  npc_op,
  input  logic [25:0] d_ins26,
  input  logic [31:0] d_btypc,
  input  logic [31:0] d_rfrs32,
  input  logic [31:0] exc_pc,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] epc,
  output logic        exl,
  output logic        pend,
  output logic        addr_err
);

  localparam logic [2:0] OP_SEQ = 3'b000;
  localparam logic [2:0] OP_BR  = 3'b001;
  localparam logic [2:0] OP_J   = 3'b010;
  localparam logic [2:0] OP_JR  = 3'b011;
  localparam logic [2:0] OP_EXC = 3'b100;
  localparam logic [2:0] OP_ERT = 3'b101;

  logic [31:0] pend_tgt;
  logic        pend_eret;
  logic [31:0] op_tgt;
  logic        jr_mis, take_exc, redir, is_eret;

  assign jr_mis   = (npc_op == OP_JR) && (d_rfrs32[1:0] != 2'b00);
  assign take_exc = (npc_op == OP_EXC) || jr_mis;
  assign is_eret  = (npc_op == OP_ERT);
  assign redir    = (npc_op == OP_BR) || (npc_op == OP_J) || (npc_op == OP_JR) || is_eret;

  always_comb begin
    op_tgt = pc + 32'(PC_INC);
    case (npc_op)
      OP_BR:   op_tgt = d_btypc;
      OP_J:    op_tgt = {pc[31:28], d_ins26, 2'b00};
      OP_JR:   op_tgt = d_rfrs32;
      OP_EXC:  op_tgt = EXC_VEC;
      OP_ERT:  op_tgt = epc;
      default: op_tgt = pc + 32'(PC_INC);
    endcase
  end

  // npc is exactly what pc loads next edge, so pc and npc cannot disagree.
  always_comb begin
    npc = op_tgt;
    if (take_exc)  npc = EXC_VEC;
    else if (stall) npc = pc;
    else if (pend)  npc = pend_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      epc       <= '0;
      exl       <= 1'b0;
      pend      <= 1'b0;
      pend_tgt  <= '0;
      pend_eret <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      pc       <= npc;
      addr_err <= 1'b0;
      if (take_exc) begin
        pend     <= 1'b0;
        exl      <= 1'b1;
        addr_err <= jr_mis;
        if (!exl) epc <= jr_mis ? pc : exc_pc;
      end else if (stall) begin
        if (redir) begin
          pend      <= 1'b1;
          pend_tgt  <= op_tgt;
          pend_eret <= is_eret;
        end
      end else if (pend) begin
        // a stalled eret only drops EXL once its return target is applied
        pend <= 1'b0;
        if (pend_eret) exl <= 1'b0;
      end else if (is_eret) begin
        exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes the expected post-edge state,
// a negedge monitor pops and compares it.
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  npc_op = 3'b000;
  logic [25:0] d_ins26 = '0;
  logic [31:0] d_btypc = '0;
  logic [31:0] d_rfrs32 = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] pc, npc, epc;
  logic        exl, pend, addr_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        exl;
    logic        pend;
    logic        ae;
    int          id;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int vec = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .npc_op(npc_op),
    .d_ins26(d_ins26), .d_btypc(d_btypc), .d_rfrs32(d_rfrs32), .exc_pc(exc_pc),
    .pc(pc), .npc(npc), .epc(epc), .exl(exl), .pend(pend), .addr_err(addr_err)
  );

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s vec%0d: got %h want %h", name, id, act, req);
  endtask

  // monitor: state is stable at negedge, half a cycle after the edge it reflects
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("pc",       e.id, pc,              e.pc);
      cmp("epc",      e.id, epc,             e.epc);
      cmp("exl",      e.id, 32'(exl),        32'(e.exl));
      cmp("pend",     e.id, 32'(pend),       32'(e.pend));
      cmp("addr_err", e.id, 32'(addr_err),   32'(e.ae));
    end
  end

  task automatic expect_st(input logic [31:0] p, input logic [31:0] ep,
                           input logic x, input logic pd, input logic ae);
    exp_t e;
    e.pc = p; e.epc = ep; e.exl = x; e.pend = pd; e.ae = ae; e.id = vec;
    vec++;
    sb.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic drv(input logic st, input logic [2:0] op);
    stall = st; npc_op = op;
  endtask

  initial begin
    @(negedge clk); #1;
    // in reset
    expect_st(32'h3000, 0, 0, 0, 0);
    rst_n = 1'b1;
    drv(0, 3'b000);
    expect_st(32'h3004, 0, 0, 0, 0);
    expect_st(32'h3008, 0, 0, 0, 0);
    expect_st(32'h300C, 0, 0, 0, 0);
    expect_st(32'h3010, 0, 0, 0, 0);
    // jump and branch
    drv(0, 3'b010); d_ins26 = 26'h0000C40;
    expect_st(32'h3100, 0, 0, 0, 0);
    drv(0, 3'b001); d_btypc = 32'h3200;
    expect_st(32'h3200, 0, 0, 0, 0);
    // stalled branch then release
    drv(1, 3'b001); d_btypc = 32'h3400;
    expect_st(32'h3200, 0, 0, 1, 0);
    drv(1, 3'b000);
    expect_st(32'h3200, 0, 0, 1, 0);
    drv(0, 3'b000);
    expect_st(32'h3400, 0, 0, 0, 0);
    // overwrite of pending target; op ignored on apply
    drv(1, 3'b010); d_ins26 = 26'h0000D40;
    expect_st(32'h3400, 0, 0, 1, 0);
    drv(1, 3'b001); d_btypc = 32'h3600;
    expect_st(32'h3400, 0, 0, 1, 0);
    drv(0, 3'b010);
    expect_st(32'h3600, 0, 0, 0, 0);
    // exception while stalled, nested exception, eret
    drv(1, 3'b100); exc_pc = 32'h3050;
    expect_st(32'h4180, 32'h3050, 1, 0, 0);
    drv(0, 3'b100); exc_pc = 32'h3060;
    expect_st(32'h4180, 32'h3050, 1, 0, 0);
    drv(0, 3'b101);
    expect_st(32'h3050, 32'h3050, 0, 0, 0);
    // stalled eret: exl clears at apply
    drv(0, 3'b100); exc_pc = 32'h3070;
    expect_st(32'h4180, 32'h3070, 1, 0, 0);
    drv(1, 3'b101);
    expect_st(32'h4180, 32'h3070, 1, 1, 0);
    drv(0, 3'b000);
    expect_st(32'h3070, 32'h3070, 0, 0, 0);
    // exception beats a pending redirect
    drv(1, 3'b001); d_btypc = 32'h3300;
    expect_st(32'h3070, 32'h3070, 0, 1, 0);
    drv(1, 3'b100); exc_pc = 32'h3080;
    expect_st(32'h4180, 32'h3080, 1, 0, 0);
    drv(0, 3'b101);
    expect_st(32'h3080, 32'h3080, 0, 0, 0);
    // misaligned jr
    drv(0, 3'b001); d_btypc = 32'h3020;
    expect_st(32'h3020, 32'h3080, 0, 0, 0);
    drv(0, 3'b011); d_rfrs32 = 32'h3102;
    expect_st(32'h4180, 32'h3020, 1, 0, 1);
    drv(0, 3'b000);
    expect_st(32'h4184, 32'h3020, 1, 0, 0);
    drv(0, 3'b011); d_rfrs32 = 32'h3104;
    expect_st(32'h3104, 32'h3020, 1, 0, 0);
    drv(0, 3'b101);
    expect_st(32'h3020, 32'h3020, 0, 0, 0);
    // eret with exl=0
    expect_st(32'h3020, 32'h3020, 0, 0, 0);
    // wrap, j upper bits, 11x as seq
    drv(0, 3'b001); d_btypc = 32'hFFFF_FFFC;
    expect_st(32'hFFFF_FFFC, 32'h3020, 0, 0, 0);
    drv(0, 3'b000);
    expect_st(32'h0000_0000, 32'h3020, 0, 0, 0);
    drv(0, 3'b001); d_btypc = 32'hA000_0000;
    expect_st(32'hA000_0000, 32'h3020, 0, 0, 0);
    drv(0, 3'b010); d_ins26 = 26'h1;
    expect_st(32'hA000_0004, 32'h3020, 0, 0, 0);
    drv(0, 3'b110);
    expect_st(32'hA000_0008, 32'h3020, 0, 0, 0);
    // async reset mid-stall with pend=1 and exl=1
    drv(0, 3'b100); exc_pc = 32'h3090;
    expect_st(32'h4180, 32'h3090, 1, 0, 0);
    drv(1, 3'b001); d_btypc = 32'h5000;
    expect_st(32'h4180, 32'h3090, 1, 1, 0);
    rst_n = 1'b0;
    #1;
    cmp("async_pc",   -1, pc,         32'h3000);
    cmp("async_pend", -1, 32'(pend),  32'd0);
    cmp("async_exl",  -1, 32'(exl),   32'd0);
    cmp("async_epc",  -1, epc,        32'd0);
    expect_st(32'h3000, 0, 0, 0, 0);
    rst_n = 1'b1;
    drv(0, 3'b000);
    expect_st(32'h3004, 0, 0, 0, 0);
    // drain with a bound
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
